regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with an integrated per-register scoreboard.
- Generalises the single-write / dual-read file to: configurable XLEN, register count and read-port count; two write ports; write-to-read bypass; busy-bit tracking of in-flight destination registers.
- Sits between decode/issue (reserve, read, hazard check) and the writeback stage(s): ALU path on write port 0, load/long-latency path on write port 1.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of 2, >= 2.
- NRD, 2, number of read ports, 1..4.
- AW, $clog2(NREGS), register address width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rd_data  output  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
- rd_busy  output  NRD  port i: addressed register has a pending write.
- wr_en  input  2  write enable per write port.
- wr_addr  input  2*AW  write addresses.
- wr_data  input  2*XLEN  write data.
- wr_clr  input  2  per write port: this write retires a reservation (clears busy).
- rsv_valid  input  1  issue requests reservation of rsv_addr.
- rsv_addr  input  AW  destination register to reserve.
- rsv_ready  output  1  reservation can be accepted this cycle.
- flush  input  1  synchronous: clear all busy bits.
- busy_cnt  output  AW+1  number of busy bits currently set.

Behaviour:
- Register 0 is hardwired: reads 0, never busy; writes, clears and reservations to address 0 are ignored. rsv_ready is 1 for rsv_addr = 0.
- Reset (async, rst=1): all registers <= 0, all busy bits <= 0, busy_cnt = 0. rd_data then shows 0 on every port and rd_busy = 0. Reset mid-operation discards every pending write and reservation.
- Write: on a clock edge with wr_en[k]=1 and wr_addr[k]!=0, register <= wr_data[k]. If both ports target the same address in the same cycle, port 1 wins for both data and bypass.
- Read is combinational, zero latency.
  - If any enabled write port targets rd_addr[i] (nonzero) in the same cycle, rd_data[i] = that wr_data (port 1 priority); otherwise it is the stored value.
  - All NRD ports are independent; any number may read the same address.
- Scoreboard busy bits:
  - Set on the edge where rsv_valid & rsv_ready & rsv_addr!=0.
  - Cleared on the edge where wr_en[k] & wr_clr[k] target that address.
  - wr_en & !wr_clr writes data without touching busy.
- rsv_ready = !busy[rsv_addr] || (a clearing write to rsv_addr is present this cycle). WAW on a busy register stalls issue; rsv_ready does not depend on rsv_valid.
- Same-cycle reservation and clearing write to the same address: busy ends set (new owner wins); data still written.
- rd_busy[i] = busy[rd_addr[i]] && !(clearing write to rd_addr[i] this cycle). A consumer may read the bypassed value in the retiring cycle.
- flush: all busy bits <= 0 at the edge; it overrides a same-cycle reservation. Register data writes in that cycle still occur.
- busy_cnt equals the popcount of the busy vector, registered, updated in the same edge as the busy bits. Maximum value is NREGS-1.
- No X propagation: out-of-range reads are impossible by construction (AW-wide addresses).

Test Plan:
- Reset then read all ports at x0..x31 -> all rd_data=0, rd_busy=0, busy_cnt=0; x0 write of 0xDEADBEEF -> x0 still reads 0.
- wr_en=2'b01, x5 <= 0x1234 and same-cycle rd_addr0=5 -> rd_data0=0x1234 (bypass); next cycle, stored x5 reads 0x1234 on all NRD ports.
- Both ports write x7 (port0 0xAAAA, port1 0x5555) -> bypass and stored value = 0x5555.
- Reserve x3 -> busy_cnt=1, rd_busy on x3 = 1; reserve x3 again -> rsv_ready=0. Port 1 clearing write x3=0x99 -> same cycle rsv_ready=1, rd_busy=0, rd_data=0x99; next cycle busy_cnt=0.
- Same cycle: reserve x4 plus clearing write to x4 (already busy) -> x4 remains busy, busy_cnt unchanged, data updated.
- Reserve x1, x2, x9 (busy_cnt=3), then flush together with rsv_valid for x10 -> busy_cnt=0, nothing busy. Assert rst mid-sequence -> immediate zeros on all outputs.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with a per-register
// scoreboard of in-flight destination registers.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   rd_addr    NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data    NRD packed read data, port i at [i*XLEN +: XLEN] (combinational)
//   rd_busy    per read port: addressed register has a pending write
//   wr_en      write enable, port 0 = ALU writeback, port 1 = load/long-latency
//   wr_addr    packed write addresses, port k at [k*AW +: AW]
//   wr_data    packed write data, port k at [k*XLEN +: XLEN]
//   wr_clr     per write port: this write retires the reservation
//   rsv_valid  issue requests reservation of rsv_addr
//   rsv_addr   destination register to reserve
//   rsv_ready  reservation can be accepted this cycle
//   flush      synchronous clear of every busy bit
//   busy_cnt   registered popcount of the busy vector
//
// Register 0 reads zero, is never busy, and ignores writes and reservations.
// When both write ports hit the same register, port 1 wins.

module regfile_mp_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [1:0]          wr_en,
    input  logic [2*AW-1:0]     wr_addr,
    input  logic [2*XLEN-1:0]   wr_data,
    input  logic [1:0]          wr_clr,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    // Number of set bits in a busy vector.
    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREGS; i++) begin
            n = n + {{AW{1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [AW:0]      busy_cnt_r;

    logic [AW-1:0]    wa_s [2];
    logic [XLEN-1:0]  wd_s [2];
    logic [1:0]       wr_hit_s;     // enabled write to a nonzero register
    logic [NREGS-1:0] clr_s;        // registers retired by a clearing write this cycle
    logic [NREGS-1:0] busy_nxt_s;
    logic             set_s;
    logic [AW-1:0]    ra_s;

    assign wa_s[0] = wr_addr[0 +: AW];
    assign wa_s[1] = wr_addr[AW +: AW];
    assign wd_s[0] = wr_data[0 +: XLEN];
    assign wd_s[1] = wr_data[XLEN +: XLEN];

    assign wr_hit_s[0] = wr_en[0] & (wa_s[0] != {AW{1'b0}});
    assign wr_hit_s[1] = wr_en[1] & (wa_s[1] != {AW{1'b0}});

    // Decode clearing writes into a per-register retire vector.
    always_comb begin
        clr_s = '0;
        for (int k = 0; k < 2; k++) begin
            clr_s[wa_s[k]] = clr_s[wa_s[k]] | (wr_hit_s[k] & wr_clr[k]);
        end
    end

    // A retiring write frees the register in the same cycle, so WAW stalls
    // only while nobody is handing the register back. busy_r[0] is always 0.
    assign rsv_ready = ~busy_r[rsv_addr] | clr_s[rsv_addr];
    assign set_s     = rsv_valid & rsv_ready & (rsv_addr != {AW{1'b0}});

    // Next busy vector: flush beats everything, a new reservation beats a retire.
    always_comb begin
        busy_nxt_s = '0;
        if (flush) begin
            busy_nxt_s = '0;
        end else begin
            busy_nxt_s           = busy_r & ~clr_s;
            busy_nxt_s[rsv_addr] = busy_nxt_s[rsv_addr] | set_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= '0;
            busy_cnt_r <= '0;
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    assign busy_cnt = busy_cnt_r;

    // Register storage; port 1 is applied last so it wins on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_hit_s[k]) begin
                    regs_r[wa_s[k]] <= wd_s[k];
                end
            end
        end
    end

    // Read ports with write bypass; outputs are forced quiet while in reset
    // so that in-flight writes cannot leak through the bypass.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra_s    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra_s = rd_addr[i*AW +: AW];
            if (rst || (ra_s == {AW{1'b0}})) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (wr_hit_s[1] && (wa_s[1] == ra_s)) begin
                rd_data[i*XLEN +: XLEN] = wd_s[1];
            end else if (wr_hit_s[0] && (wa_s[0] == ra_s)) begin
                rd_data[i*XLEN +: XLEN] = wd_s[0];
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_r[ra_s];
            end
            rd_busy[i] = ~rst & busy_r[ra_s] & ~clr_s[ra_s];
        end
    end

endmodule
